spi_flash_emu: RTL and testbench
================================

SPI_FLASH_EMU -- requirements
Module: spi_flash_emu

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 enable  in  1  1 = respond to SPI transactions; sampled only at CS falling edge.
REQ-004 spi_cs  in  1  SPI chip select, active-low, asynchronous to clk.
REQ-005 spi_clk  in  1  SPI clock, mode 0, asynchronous to clk.
REQ-006 spi_si  in  1  SPI data from master.
REQ-007 spi_so  out  1  SPI data to master; 0 when not driving.
REQ-008 spi_so_oe  out  1  output enable for spi_so pad.
REQ-009 mem_addr  out  22  word address of the 32-bit word being fetched.
REQ-010 mem_req  out  1  fetch request; held high until mem_ack.
REQ-011 mem_ack  in  1  one-cycle fetch completion; mem_data is valid in the same cycle.
REQ-012 mem_data  in  32  fetched word, big-endian: byte 0 = [31:24].
REQ-013 cmd_stb  out  1  one-cycle pulse when a command byte completes.
REQ-014 cmd_byte  out  8  last completed command byte; valid with cmd_stb, then held.
REQ-015 underrun  out  1  sticky; set when a data bit is needed before its word arrived.

Function
REQ-016 spi_cs, spi_clk and spi_si SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized values.
REQ-017 SCK half-period SHALL be at least 6 clk cycles; faster SCK is unsupported and unchecked.
REQ-018 FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
REQ-019 IDLE: on CS falling edge, go to CMD if enable=1, else IGNORE; clear bit_cnt, cmd, addr.
REQ-020 CMD: shift spi_si MSB-first on each SCK rising edge; after the 8th bit, pulse cmd_stb and load cmd_byte.
REQ-021 CMD exit: byte 0x03 goes to ADDR; any other byte goes to IGNORE.
REQ-022 ADDR: shift 24 address bits MSB-first on SCK rising edges.
REQ-023 On the 24th address bit: raise mem_req with mem_addr=addr[23:2], record lane=addr[1:0], go to DATA.
REQ-024 DATA: on each SCK falling edge, drive spi_so = bit (7-bit_idx) of the current byte lane of the word buffer; spi_so_oe=1 from the first such edge until CS rises.
REQ-025 Byte completion: after the 8th falling edge of a byte, lane increments; lane wrap 3->0 advances to the prefetched word.
REQ-026 Prefetch: when lane 3 starts shifting, issue mem_req for mem_addr+1; the word address wraps 0x3FFFFF->0x000000.
REQ-027 Handshake: mem_req SHALL stay high until the cycle of mem_ack, then fall in the next cycle; at most one request is outstanding.
REQ-028 Underrun: if a falling edge needs a word not yet acked, drive spi_so=0 for that bit and set underrun; the late word is used from the next byte boundary.
REQ-029 IGNORE: spi_so_oe=0; wait for CS rising edge.
REQ-030 CS rising edge in any state: go to IDLE, spi_so_oe=0, spi_so=0; a partial command byte SHALL NOT produce cmd_stb.
REQ-031 A pending mem_req at CS rise SHALL stay high until mem_ack; that word SHALL be discarded.
REQ-032 A new CS falling edge while a stale request is pending SHALL still be accepted; the stale ack SHALL be discarded, never used as data.
REQ-033 SCK edges while CS is high SHALL be ignored.
REQ-034 underrun SHALL clear only on reset.

Reset
REQ-035 While reset=0: state=IDLE; spi_so=0, spi_so_oe=0, mem_req=0, mem_addr=0, cmd_stb=0, cmd_byte=0, underrun=0; synchronizer flops=1 (CS idle high).
REQ-036 On deassertion, the first transaction SHALL be recognized only after a CS falling edge.

Verification
REQ-037 READ 0x03 at addr 0x000005, mem word 0x11223344 at word 1, 0x55667788 at word 2, ack in 2 cycles, 6 bytes clocked -> spi_so bytes 22,33,44,55,66,77; mem_addr 0x000001 then 0x000002; underrun=0.
REQ-038 Cmd 0x9F followed by 16 SCK -> cmd_stb pulse with cmd_byte=0x9F; spi_so_oe=0 throughout; no mem_req.
REQ-039 READ at 0xFFFFFC, 8 bytes -> second fetch mem_addr=0x000000.
REQ-040 mem_ack delayed 40 clk after first request -> underrun=1; spi_so=0 for missing bits; stays 1 after CS rise.
REQ-041 CS rises after 5 address bits, then a new READ at 0x000000 -> no stale data; correct first byte from word 0.
REQ-042 reset pulled low mid-DATA -> all outputs return to REQ-035 values asynchronously.

Source files
------------

// File: rtl/spi_flash_emu_if.sv
// Word-fetch bus between the SPI flash emulator (master) and its backing memory (slave).
`timescale 1ns/1ps
interface spi_flash_emu_if;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/spi_flash_emu.sv
// SPI (mode 0) serial flash emulator answering READ (0x03) from a 32-bit word memory,
// with one-word prefetch so bytes stream without gaps.
`timescale 1ns/1ps
module spi_flash_emu (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_enable,
    input  logic            i_spi_cs,
    input  logic            i_spi_clk,
    input  logic            i_spi_si,
    output logic            o_spi_so,
    output logic            o_spi_so_oe,
    output logic            o_cmd_stb,
    output logic [7:0]      o_cmd_byte,
    output logic            o_underrun,
    spi_flash_emu_if.master mem
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

    state_t      r_state;
    logic [2:0]  r_cs_sync, r_sck_sync;
    logic [1:0]  r_si_sync;
    logic [4:0]  r_bit_cnt;
    logic [7:0]  r_cmd;
    logic [23:0] r_addr;
    logic [1:0]  r_lane;
    logic [2:0]  r_bit_idx;
    logic        r_byte_bad;
    logic [21:0] r_word_addr;
    logic [31:0] r_cur_word, r_nxt_word;
    logic        r_cur_valid, r_nxt_valid;
    logic        r_mem_req;
    logic [21:0] r_mem_addr;
    logic        r_pend, r_pf_need, r_discard;
    logic [21:0] r_pend_addr;
    logic        r_so, r_so_oe, r_cmd_stb, r_underrun;
    logic [7:0]  r_cmd_byte;

    logic        w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall, w_si;
    logic        w_ack_ok, w_cur_bit;
    logic [7:0]  w_cmd_next, w_cur_byte;
    logic [23:0] w_addr_next;

    // Bit [1] is the synchronized level, bit [2] its previous value for edge detection.
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_sck_rise  = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall  = ~r_sck_sync[1] & r_sck_sync[2];
    assign w_si        = r_si_sync[1];
    assign w_cmd_next  = {r_cmd[6:0], w_si};
    assign w_addr_next = {r_addr[22:0], w_si};
    assign w_ack_ok    = mem.mem_ack & r_mem_req & ~r_discard;

    always_comb begin
        w_cur_byte = r_cur_word[31:24];
        case (r_lane)
            2'd0: w_cur_byte = r_cur_word[31:24];
            2'd1: w_cur_byte = r_cur_word[23:16];
            2'd2: w_cur_byte = r_cur_word[15:8];
            2'd3: w_cur_byte = r_cur_word[7:0];
            default: w_cur_byte = r_cur_word[31:24];
        endcase
    end
    assign w_cur_bit = w_cur_byte[3'd7 - r_bit_idx];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_cs_sync   <= 3'b111;
            r_sck_sync  <= 3'b111;
            r_si_sync   <= 2'b11;
            r_bit_cnt   <= 5'd0;
            r_cmd       <= 8'd0;
            r_addr      <= 24'd0;
            r_lane      <= 2'd0;
            r_bit_idx   <= 3'd0;
            r_byte_bad  <= 1'b0;
            r_word_addr <= 22'd0;
            r_cur_word  <= 32'd0;
            r_nxt_word  <= 32'd0;
            r_cur_valid <= 1'b0;
            r_nxt_valid <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 22'd0;
            r_pend      <= 1'b0;
            r_pend_addr <= 22'd0;
            r_pf_need   <= 1'b0;
            r_discard   <= 1'b0;
            r_so        <= 1'b0;
            r_so_oe     <= 1'b0;
            r_cmd_stb   <= 1'b0;
            r_cmd_byte  <= 8'd0;
            r_underrun  <= 1'b0;
        end else begin
            r_cs_sync  <= {r_cs_sync[1:0], i_spi_cs};
            r_sck_sync <= {r_sck_sync[1:0], i_spi_clk};
            r_si_sync  <= {r_si_sync[0], i_spi_si};
            r_cmd_stb  <= 1'b0;

            // Single-outstanding fetch engine: the first word of a READ beats the prefetch.
            if (mem.mem_ack && r_mem_req) begin
                r_mem_req <= 1'b0;
                r_discard <= 1'b0;
            end else if (!r_mem_req && !w_cs_rise) begin
                if (r_pend) begin
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= r_pend_addr;
                    r_pend     <= 1'b0;
                end else if (r_pf_need) begin
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= r_word_addr + 22'd1;
                    r_pf_need  <= 1'b0;
                end
            end

            if (w_ack_ok) begin
                if (r_cur_valid) begin
                    r_nxt_word  <= mem.mem_data;
                    r_nxt_valid <= 1'b1;
                end else begin
                    r_cur_word  <= mem.mem_data;
                    r_cur_valid <= 1'b1;
                end
            end

            if (w_cs_rise) begin
                r_state     <= IDLE;
                r_so        <= 1'b0;
                r_so_oe     <= 1'b0;
                r_pend      <= 1'b0;
                r_pf_need   <= 1'b0;
                r_cur_valid <= 1'b0;
                r_nxt_valid <= 1'b0;
                r_discard   <= r_mem_req & ~mem.mem_ack;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= i_enable ? CMD : IGNORE;
                            r_bit_cnt <= 5'd0;
                            r_cmd     <= 8'd0;
                            r_addr    <= 24'd0;
                        end
                    end
                    CMD: begin
                        if (w_sck_rise) begin
                            r_cmd <= w_cmd_next;
                            if (r_bit_cnt == 5'd7) begin
                                r_cmd_stb  <= 1'b1;
                                r_cmd_byte <= w_cmd_next;
                                r_bit_cnt  <= 5'd0;
                                r_state    <= (w_cmd_next == 8'h03) ? ADDR : IGNORE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (w_sck_rise) begin
                            r_addr <= w_addr_next;
                            if (r_bit_cnt == 5'd23) begin
                                r_pend      <= 1'b1;
                                r_pend_addr <= w_addr_next[23:2];
                                r_word_addr <= w_addr_next[23:2];
                                r_lane      <= w_addr_next[1:0];
                                r_pf_need   <= (w_addr_next[1:0] == 2'd3);
                                r_bit_idx   <= 3'd0;
                                r_byte_bad  <= 1'b0;
                                r_state     <= DATA;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (w_sck_fall) begin
                            r_so_oe <= 1'b1;
                            // A byte that started without its word stays zero to its end.
                            if (!r_cur_valid) begin
                                r_so       <= 1'b0;
                                r_underrun <= 1'b1;
                                r_byte_bad <= 1'b1;
                            end else begin
                                r_so <= r_byte_bad ? 1'b0 : w_cur_bit;
                            end
                            if (r_bit_idx == 3'd7) begin
                                r_bit_idx  <= 3'd0;
                                r_byte_bad <= 1'b0;
                                r_lane     <= r_lane + 2'd1;
                                if (r_lane == 2'd2) r_pf_need <= 1'b1;
                                if (r_lane == 2'd3) begin
                                    r_word_addr <= r_word_addr + 22'd1;
                                    r_nxt_valid <= 1'b0;
                                    if (r_nxt_valid) begin
                                        r_cur_word  <= r_nxt_word;
                                        r_cur_valid <= 1'b1;
                                    end else if (w_ack_ok) begin
                                        r_cur_word  <= mem.mem_data;
                                        r_cur_valid <= 1'b1;
                                    end else begin
                                        r_cur_valid <= 1'b0;
                                    end
                                end
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end
                    end
                    IGNORE: ;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_spi_so     = r_so;
    assign o_spi_so_oe  = r_so_oe;
    assign o_cmd_stb    = r_cmd_stb;
    assign o_cmd_byte   = r_cmd_byte;
    assign o_underrun   = r_underrun;
    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_mem_addr;
endmodule

// File: tb/tb_spi_flash_emu.sv
// Directed bench for spi_flash_emu: an SPI master driving READ/other commands against
// a small word-memory model with programmable ack latency.
`timescale 1ns/1ps
module tb_spi_flash_emu;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset, enable, spiCs, spiClk, spiSi;
    logic spiSo, spiSoOe, cmdStb, underrun;
    logic [7:0] cmdByte;

    int vectorCount = 0;
    int missCount = 0;
    int ackDelay = 2;
    int reqTotal = 0;
    int stbCount = 0;
    int oeCycles = 0;
    logic [7:0]  stbByte = 8'h00;
    logic [21:0] reqAddrs [0:127];
    logic [7:0]  rxBytes [0:15];

    spi_flash_emu_if mif();

    spi_flash_emu dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_enable    (enable),
        .i_spi_cs    (spiCs),
        .i_spi_clk   (spiClk),
        .i_spi_si    (spiSi),
        .o_spi_so    (spiSo),
        .o_spi_so_oe (spiSoOe),
        .o_cmd_stb   (cmdStb),
        .o_cmd_byte  (cmdByte),
        .o_underrun  (underrun),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [21:0] a);
        case (a)
            22'h000000: memWord = 32'hCAFEF00D;
            22'h000001: memWord = 32'h11223344;
            22'h000002: memWord = 32'h55667788;
            22'h3FFFFF: memWord = 32'hA1B2C3D4;
            default:    memWord = {10'h000, a};
        endcase
    endfunction

    // Memory model: latency is latched when a request is first seen.
    initial begin
        int d;
        mif.mem_ack  = 1'b0;
        mif.mem_data = 32'd0;
        forever begin
            @(negedge clk);
            if (mif.mem_req === 1'b1) begin
                d = ackDelay;
                if (reqTotal < 128) reqAddrs[reqTotal] = mif.mem_addr;
                reqTotal++;
                repeat (d - 1) @(negedge clk);
                mif.mem_data = memWord(mif.mem_addr);
                mif.mem_ack  = 1'b1;
                @(negedge clk);
                mif.mem_ack  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmdStb) begin
            stbCount++;
            stbByte = cmdByte;
        end
        if (spiSoOe) oeCycles++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic halfWait();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spiBit(input logic siVal, output logic soVal);
        spiSi = siVal;
        halfWait();
        soVal = spiSo;
        spiClk = 1'b1;
        halfWait();
        spiClk = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] header, input int headerBits, input int dataBytes);
        logic b;
        logic [7:0] acc;
        spiCs = 1'b0;
        halfWait();
        for (int i = 0; i < headerBits; i++) spiBit(header[31 - i], b);
        for (int k = 0; k < dataBytes; k++) begin
            acc = 8'h00;
            for (int j = 0; j < 8; j++) begin
                spiBit(1'b0, b);
                acc = {acc[6:0], b};
            end
            rxBytes[k] = acc;
        end
        halfWait();
        spiCs = 1'b1;
        halfWait();
        halfWait();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_so"},      {31'd0, spiSo},        32'd0);
        checkOutput({tag, "_so_oe"},   {31'd0, spiSoOe},      32'd0);
        checkOutput({tag, "_req"},     {31'd0, mif.mem_req},  32'd0);
        checkOutput({tag, "_addr"},    {10'd0, mif.mem_addr}, 32'd0);
        checkOutput({tag, "_stb"},     {31'd0, cmdStb},       32'd0);
        checkOutput({tag, "_cmdbyte"}, {24'd0, cmdByte},      32'd0);
        checkOutput({tag, "_underrun"},{31'd0, underrun},     32'd0);
    endtask

    initial begin
        int base, stb0, oe0, req0;
        logic b;
        reset = 1'b0; enable = 1'b1; spiCs = 1'b1; spiClk = 1'b0; spiSi = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("rst");
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // Basic READ crossing a word boundary.
        ackDelay = 2;
        base = reqTotal;
        applyStimulus({8'h03, 24'h000005}, 32, 6);
        checkOutput("rd_b0", {24'd0, rxBytes[0]}, 32'h22);
        checkOutput("rd_b1", {24'd0, rxBytes[1]}, 32'h33);
        checkOutput("rd_b2", {24'd0, rxBytes[2]}, 32'h44);
        checkOutput("rd_b3", {24'd0, rxBytes[3]}, 32'h55);
        checkOutput("rd_b4", {24'd0, rxBytes[4]}, 32'h66);
        checkOutput("rd_b5", {24'd0, rxBytes[5]}, 32'h77);
        checkOutput("rd_addr0", {10'd0, reqAddrs[base]},     32'h000001);
        checkOutput("rd_addr1", {10'd0, reqAddrs[base + 1]}, 32'h000002);
        checkOutput("rd_oe_after", {31'd0, spiSoOe}, 32'd0);
        repeat (50) @(negedge clk);

        // Non-READ command: strobe only.
        stb0 = stbCount; oe0 = oeCycles; req0 = reqTotal;
        applyStimulus({8'h9F, 24'h000000}, 8, 2);
        checkOutput("id_stb", stbCount - stb0, 1);
        checkOutput("id_byte", {24'd0, stbByte}, 32'h9F);
        checkOutput("id_oe", oeCycles - oe0, 0);
        checkOutput("id_req", reqTotal - req0, 0);
        checkOutput("id_held", {24'd0, cmdByte}, 32'h9F);

        // Partial command byte produces no strobe.
        stb0 = stbCount;
        applyStimulus(32'h0000_0000, 4, 0);
        checkOutput("part_stb", stbCount - stb0, 0);
        checkOutput("part_held", {24'd0, cmdByte}, 32'h9F);

        // Disabled at CS fall: transaction ignored.
        enable = 1'b0;
        stb0 = stbCount; oe0 = oeCycles; req0 = reqTotal;
        applyStimulus({8'h03, 24'h000004}, 32, 1);
        checkOutput("dis_stb", stbCount - stb0, 0);
        checkOutput("dis_req", reqTotal - req0, 0);
        checkOutput("dis_oe", oeCycles - oe0, 0);
        enable = 1'b1;

        // Word address wrap at top of memory.
        base = reqTotal;
        applyStimulus({8'h03, 24'hFFFFFC}, 32, 8);
        checkOutput("wrap_addr0", {10'd0, reqAddrs[base]},     32'h3FFFFF);
        checkOutput("wrap_addr1", {10'd0, reqAddrs[base + 1]}, 32'h000000);
        checkOutput("wrap_b0", {24'd0, rxBytes[0]}, 32'hA1);
        checkOutput("wrap_b3", {24'd0, rxBytes[3]}, 32'hD4);
        checkOutput("wrap_b4", {24'd0, rxBytes[4]}, 32'hCA);
        checkOutput("wrap_b7", {24'd0, rxBytes[7]}, 32'h0D);
        repeat (50) @(negedge clk);

        // Abort after 5 address bits, then a clean READ at 0.
        base = reqTotal;
        applyStimulus({8'h03, 24'h000000}, 13, 0);
        applyStimulus({8'h03, 24'h000000}, 32, 2);
        checkOutput("abort_addr", {10'd0, reqAddrs[base]}, 32'h000000);
        checkOutput("abort_b0", {24'd0, rxBytes[0]}, 32'hCA);
        checkOutput("abort_b1", {24'd0, rxBytes[1]}, 32'hFE);
        checkOutput("pre_underrun", {31'd0, underrun}, 32'd0);
        repeat (50) @(negedge clk);

        // Late first word: first byte zeroed, sticky underrun.
        ackDelay = 40;
        applyStimulus({8'h03, 24'h000004}, 32, 2);
        checkOutput("late_b0", {24'd0, rxBytes[0]}, 32'h00);
        checkOutput("late_b1", {24'd0, rxBytes[1]}, 32'h22);
        checkOutput("late_underrun", {31'd0, underrun}, 32'd1);
        repeat (80) @(negedge clk);

        // Stale request outstanding across CS: its word must never be used.
        ackDelay = 60;
        applyStimulus({8'h03, 24'h000008}, 32, 0);
        ackDelay = 2;
        applyStimulus({8'h03, 24'h000000}, 32, 2);
        checkOutput("stale_b0", {24'd0, rxBytes[0]}, 32'hCA);
        checkOutput("stale_b1", {24'd0, rxBytes[1]}, 32'hFE);
        checkOutput("stale_underrun", {31'd0, underrun}, 32'd1);
        repeat (50) @(negedge clk);

        // Asynchronous reset in the middle of a data phase.
        spiCs = 1'b0;
        halfWait();
        for (int i = 0; i < 32; i++) spiBit(((32'h03000004 >> (31 - i)) & 32'd1) != 32'd0, b);
        for (int j = 0; j < 8; j++) spiBit(1'b0, b);
        checkOutput("mid_oe", {31'd0, spiSoOe}, 32'd1);
        checkOutput("mid_addr", {10'd0, mif.mem_addr}, 32'h000001);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkResetValues("async");
        spiCs = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
